// File: rtl/prog_mem_loader_pkg.sv
// rtl/prog_mem_loader_pkg.sv - shared types and constants for the program memory boot loader
//
// Purpose: loader FSM state encoding, word packing geometry and the write byte-enable constant.
// Ports:   none (package)

package prog_mem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_COLLECT,
        ST_WRITE,
        ST_WAIT_RV,
        ST_DONE
    } state_t;

    localparam int          BYTES_PER_WORD = 4;
    localparam logic [3:0]  BE_ALL         = 4'b1111;

    // States in which the loader consumes stream bytes.
    function automatic logic takes_bytes(input state_t s);
        return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_COLLECT);
    endfunction

endpackage

// File: rtl/prog_mem_loader_byte_packer.sv
// rtl/prog_mem_loader_byte_packer.sv - packs a byte stream LSB-first into 32-bit words
//
// Purpose: collects BYTES_PER_WORD bytes; on the last byte of a word, o_word_valid pulses
//          combinationally with the complete word on o_word.
// Ports:   i_clk, i_rst (sync, active-high), i_clear (drop partial word),
//          i_byte_en/i_byte (accepted byte), o_word_valid/o_word (completed word).

module prog_mem_loader_byte_packer
    import prog_mem_loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clear,
    input  logic        i_byte_en,
    input  logic [7:0]  i_byte,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    localparam int IDX_W = $clog2(BYTES_PER_WORD);

    logic [IDX_W-1:0] r_idx;
    logic [23:0]      r_shift;

    // Only the first three bytes are stored; the fourth comes straight from the input so the
    // full word is available in the same cycle it completes.
    assign o_word       = {i_byte, r_shift};
    assign o_word_valid = i_byte_en && (r_idx == IDX_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_idx   <= '0;
            r_shift <= '0;
        end else if (i_byte_en) begin
            r_idx   <= r_idx + 1'b1;
            r_shift <= {i_byte, r_shift[23:8]};
        end
    end

endmodule

// File: rtl/prog_mem_loader.sv
// rtl/prog_mem_loader.sv - boot loader writing a length-prefixed byte image into program memory
//
// Purpose: receives 2 length bytes (word count N, little-endian) then 4*N payload bytes, packs
//          them into words and writes them from BASE_ADDR upward over a req/gnt/rvalid port.
//          Keeps the core held in reset until a load completes without error.
// Ports:   i_clk, i_rst (sync, active-high), i_start (load pulse),
//          i_byte_valid/i_byte_data/o_byte_ready (byte stream),
//          o_mem_req/i_mem_gnt/i_mem_rvalid/o_mem_addr/o_mem_we/o_mem_be/o_mem_wdata (memory port),
//          o_busy/o_done/o_err/o_core_hold/o_words_written (status).

module prog_mem_loader
    import prog_mem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int BASE_ADDR      = 0,
    parameter int MAX_WORDS      = 1024,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_byte_valid,
    input  logic [7:0]            i_byte_data,
    output logic                  o_byte_ready,
    output logic                  o_mem_req,
    input  logic                  i_mem_gnt,
    input  logic                  i_mem_rvalid,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_we,
    output logic [3:0]            o_mem_be,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic                  o_core_hold,
    output logic [15:0]           o_words_written
);

    state_t                r_state;
    state_t                w_state_next;
    logic [7:0]            r_len_lo;
    logic [15:0]           r_len;
    logic [15:0]           r_words;
    logic [15:0]           r_timer;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_done;
    logic                  r_err;
    logic                  r_core_hold;

    logic                  w_byte_fire;
    logic                  w_start_ok;
    logic [15:0]           w_len_full;
    logic                  w_len_zero;
    logic                  w_len_big;
    logic                  w_timing;
    logic                  w_timeout;
    logic                  w_last_word;
    logic                  w_word_valid;
    logic [31:0]           w_word;

    assign o_byte_ready    = takes_bytes(r_state);
    assign o_mem_req       = (r_state == ST_WRITE);
    assign o_mem_we        = o_mem_req;
    assign o_mem_be        = BE_ALL;
    assign o_mem_addr      = r_addr;
    assign o_mem_wdata     = r_wdata;
    assign o_busy          = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign o_done          = r_done;
    assign o_err           = r_err;
    assign o_core_hold     = r_core_hold;
    assign o_words_written = r_words;

    assign w_byte_fire = i_byte_valid && o_byte_ready;
    assign w_start_ok  = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_len_full  = {i_byte_data, r_len_lo};
    assign w_len_zero  = (w_len_full == 16'd0);
    assign w_len_big   = ({1'b0, w_len_full} > 17'(MAX_WORDS));
    assign w_last_word = ((r_words + 16'd1) == r_len);

    // The idle timer only runs while waiting on the stream; memory stalls do not count.
    assign w_timing  = (r_state == ST_LEN_HI) || (r_state == ST_COLLECT);
    assign w_timeout = (TIMEOUT_CYCLES != 0) && w_timing && !w_byte_fire &&
                       (r_timer == 16'(TIMEOUT_CYCLES - 1));

    prog_mem_loader_byte_packer u_packer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clear      (w_start_ok || w_timeout),
        .i_byte_en    (w_byte_fire && (r_state == ST_COLLECT)),
        .i_byte       (i_byte_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:    if (i_start) w_state_next = ST_LEN_LO;
            ST_LEN_LO:  if (w_byte_fire) w_state_next = ST_LEN_HI;
            ST_LEN_HI: begin
                if (w_byte_fire) begin
                    w_state_next = (w_len_zero || w_len_big) ? ST_DONE : ST_COLLECT;
                end else if (w_timeout) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_COLLECT: begin
                if (w_word_valid)   w_state_next = ST_WRITE;
                else if (w_timeout) w_state_next = ST_DONE;
            end
            ST_WRITE:   if (i_mem_gnt) w_state_next = ST_WAIT_RV;
            ST_WAIT_RV: if (i_mem_rvalid) w_state_next = w_last_word ? ST_DONE : ST_COLLECT;
            ST_DONE:    if (i_start) w_state_next = ST_LEN_LO;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_len_lo    <= '0;
            r_len       <= '0;
            r_words     <= '0;
            r_timer     <= '0;
            r_addr      <= ADDR_WIDTH'(BASE_ADDR);
            r_wdata     <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_core_hold <= 1'b1;
        end else begin
            r_state <= w_state_next;

            if (w_start_ok) begin
                r_len_lo    <= '0;
                r_len       <= '0;
                r_words     <= '0;
                r_timer     <= '0;
                r_addr      <= ADDR_WIDTH'(BASE_ADDR);
                r_done      <= 1'b0;
                r_err       <= 1'b0;
                r_core_hold <= 1'b1;
            end

            if (w_timing) begin
                r_timer <= w_byte_fire ? 16'd0 : r_timer + 16'd1;
            end

            if (w_timeout) begin
                r_done <= 1'b1;
                r_err  <= 1'b1;
            end

            if ((r_state == ST_LEN_LO) && w_byte_fire) begin
                r_len_lo <= i_byte_data;
            end

            if ((r_state == ST_LEN_HI) && w_byte_fire) begin
                r_len <= w_len_full;
                if (w_len_big) begin
                    r_done <= 1'b1;
                    r_err  <= 1'b1;
                end else if (w_len_zero) begin
                    r_done      <= 1'b1;
                    r_core_hold <= 1'b0;
                end
            end

            if ((r_state == ST_COLLECT) && w_word_valid) begin
                r_wdata <= DATA_WIDTH'(w_word);
            end

            // Address wraps naturally at 2^ADDR_WIDTH.
            if ((r_state == ST_WAIT_RV) && i_mem_rvalid) begin
                r_words <= r_words + 16'd1;
                r_addr  <= r_addr + 1'b1;
                if (w_last_word) begin
                    r_done      <= 1'b1;
                    r_core_hold <= 1'b0;
                end
            end
        end
    end

endmodule
